// File: rtl/demux2_buf.sv
// +----------------------------------------------------------------------------+
// | Module   : demux2_buf                                                      |
// | Purpose  : Routes one valid/ready stream into two independent FIFO queues. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module demux2_buf #(
  parameter int W     = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_data,
  input  logic                     adr,
  output logic                     y0_valid,
  input  logic                     y0_ready,
  output logic [W-1:0]             y0,
  output logic [$clog2(DEPTH):0]   y0_count,
  output logic                     y1_valid,
  input  logic                     y1_ready,
  output logic [W-1:0]             y1,
  output logic [$clog2(DEPTH):0]   y1_count
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;

  logic w_accept;

  // Ready depends only on the addressed queue's occupancy, never on a pop.
  assign in_ready = adr ? ~g_queue[1].w_full : ~g_queue[0].w_full;
  assign w_accept = in_valid & in_ready;

  for (genvar g = 0; g < 2; g++) begin : g_queue
    logic [W-1:0]    r_mem [DEPTH];
    logic [c_AW-1:0] r_rptr;
    logic [c_AW-1:0] r_wptr;
    logic [c_CW-1:0] r_count;
    logic            w_rdy;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic [W-1:0]    w_head;

    assign w_rdy  = (g == 0) ? y0_ready : y1_ready;
    assign w_push = w_accept & (adr == 1'(g));
    assign w_pop  = (r_count != '0) & w_rdy;
    assign w_full = (r_count == c_CW'(DEPTH));
    assign w_head = r_mem[r_rptr];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rptr  <= '0;
        r_wptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end

    // Storage is left uncleared by reset; only pointers define validity.
    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= in_data;
    end
  end

  assign y0_valid = (g_queue[0].r_count != '0);
  assign y0       = g_queue[0].w_head;
  assign y0_count = g_queue[0].r_count;
  assign y1_valid = (g_queue[1].r_count != '0);
  assign y1       = g_queue[1].w_head;
  assign y1_count = g_queue[1].r_count;

endmodule

`default_nettype wire

// File: tb/tb_demux2_buf.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_demux2_buf                                                   |
// | Purpose  : Directed self-checking bench for demux2_buf (W=4, DEPTH=2).     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_demux2_buf;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       adr;
  logic       y0_valid, y0_ready;
  logic [3:0] y0;
  logic [1:0] y0_count;
  logic       y1_valid, y1_ready;
  logic [3:0] y1;
  logic [1:0] y1_count;

  int n_cmp = 0;
  int n_err = 0;

  demux2_buf #(.W(4), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .adr(adr),
    .y0_valid(y0_valid), .y0_ready(y0_ready), .y0(y0), .y0_count(y0_count),
    .y1_valid(y1_valid), .y1_ready(y1_ready), .y1(y1), .y1_count(y1_count)
  );

  always #5 clk = ~clk;

  task automatic idle();
    in_valid = 0; y0_ready = 0; y1_ready = 0; adr = 0; in_data = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    #12;
    n_cmp++; if (y0_valid !== 1'b0) begin n_err++; $display("FAIL rst_y0_valid got %b exp 0", y0_valid); end
    n_cmp++; if (y1_valid !== 1'b0) begin n_err++; $display("FAIL rst_y1_valid got %b exp 0", y1_valid); end
    n_cmp++; if (y0_count !== 2'd0) begin n_err++; $display("FAIL rst_y0_count got %0d exp 0", y0_count); end
    n_cmp++; if (y1_count !== 2'd0) begin n_err++; $display("FAIL rst_y1_count got %0d exp 0", y1_count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    @(negedge clk); rst = 0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_single_push();
    @(negedge clk); in_valid = 1; adr = 0; in_data = 4'hA; y0_ready = 0;
    @(negedge clk); in_valid = 0;
    n_cmp++; if (y0_valid !== 1'b1) begin n_err++; $display("FAIL single_y0_valid got %b exp 1", y0_valid); end
    n_cmp++; if (y0 !== 4'hA) begin n_err++; $display("FAIL single_y0 got %h exp a", y0); end
    n_cmp++; if (y0_count !== 2'd1) begin n_err++; $display("FAIL single_y0_count got %0d exp 1", y0_count); end
    n_cmp++; if (y1_valid !== 1'b0) begin n_err++; $display("FAIL single_y1_valid got %b exp 0", y1_valid); end
    y0_ready = 1;
    @(negedge clk); y0_ready = 0;
    n_cmp++; if (y0_count !== 2'd0) begin n_err++; $display("FAIL single_drain_count got %0d exp 0", y0_count); end
  endtask

  task automatic test_full_and_pop();
    y1_ready = 0;
    @(negedge clk); in_valid = 1; adr = 1; in_data = 4'h3;
    @(negedge clk); in_data = 4'h5;
    @(negedge clk); in_data = 4'h9;
    #1;
    n_cmp++; if (y1_count !== 2'd2) begin n_err++; $display("FAIL full_y1_count got %0d exp 2", y1_count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_adr1 got %b exp 0", in_ready); end
    adr = 0; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_adr0 got %b exp 1", in_ready); end
    adr = 1;
    // third push held across an edge must be refused
    @(negedge clk);
    n_cmp++; if (y1_count !== 2'd2) begin n_err++; $display("FAIL full_hold_count got %0d exp 2", y1_count); end
    n_cmp++; if (y1 !== 4'h3) begin n_err++; $display("FAIL full_hold_head got %h exp 3", y1); end
    y1_ready = 1; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_no_bypass got %b exp 0", in_ready); end
    @(negedge clk); y1_ready = 0; #1;
    n_cmp++; if (y1_count !== 2'd1) begin n_err++; $display("FAIL fullpop_count got %0d exp 1", y1_count); end
    n_cmp++; if (y1 !== 4'h5) begin n_err++; $display("FAIL fullpop_head got %h exp 5", y1); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fullpop_ready got %b exp 1", in_ready); end
    @(negedge clk); in_valid = 0;
    n_cmp++; if (y1_count !== 2'd2) begin n_err++; $display("FAIL retry_count got %0d exp 2", y1_count); end
    y1_ready = 1;
    @(negedge clk);
    n_cmp++; if (y1 !== 4'h9) begin n_err++; $display("FAIL retry_head got %h exp 9", y1); end
    @(negedge clk); y1_ready = 0;
    n_cmp++; if (y1_valid !== 1'b0) begin n_err++; $display("FAIL retry_drained got %b exp 0", y1_valid); end
  endtask

  task automatic test_push_pop();
    @(negedge clk); in_valid = 1; adr = 0; in_data = 4'h2;
    @(negedge clk); in_data = 4'h7; y0_ready = 1;
    n_cmp++; if (y0 !== 4'h2) begin n_err++; $display("FAIL pp_pre_head got %h exp 2", y0); end
    @(negedge clk); in_valid = 0; y0_ready = 0;
    n_cmp++; if (y0_count !== 2'd1) begin n_err++; $display("FAIL pp_count got %0d exp 1", y0_count); end
    n_cmp++; if (y0 !== 4'h7) begin n_err++; $display("FAIL pp_head got %h exp 7", y0); end
    y0_ready = 1;
    @(negedge clk); y0_ready = 0;
  endtask

  task automatic test_empty_pop();
    y0_ready = 1; y1_ready = 1; in_valid = 0; adr = 1; in_data = 4'hF;
    repeat (3) @(negedge clk);
    n_cmp++; if (y0_count !== 2'd0) begin n_err++; $display("FAIL empty_y0_count got %0d exp 0", y0_count); end
    n_cmp++; if (y1_count !== 2'd0) begin n_err++; $display("FAIL empty_y1_count got %0d exp 0", y1_count); end
    y0_ready = 0; y1_ready = 0;
    in_valid = 1; adr = 0; in_data = 4'hC;
    @(negedge clk); in_valid = 1; adr = 0; in_data = 4'hD;
    @(negedge clk); in_valid = 0;
    n_cmp++; if (y0 !== 4'hC) begin n_err++; $display("FAIL empty_then_head got %h exp c", y0); end
    n_cmp++; if (y0_count !== 2'd2) begin n_err++; $display("FAIL empty_then_count got %0d exp 2", y0_count); end
    y0_ready = 1;
    @(negedge clk);
    n_cmp++; if (y0 !== 4'hD) begin n_err++; $display("FAIL empty_then_second got %h exp d", y0); end
    @(negedge clk); y0_ready = 0;
  endtask

  task automatic test_stream();
    logic [3:0] q0[$];
    logic [3:0] q1[$];
    int next = 0;
    int got = 0;
    int cyc = 0;
    bit exp_rdy;
    while ((next < 16 || q0.size() != 0 || q1.size() != 0) && cyc < 300) begin
      @(negedge clk); cyc++;
      n_cmp++; if (y0_valid !== (q0.size() != 0)) begin n_err++; $display("FAIL stream_y0_valid got %b exp %b", y0_valid, q0.size() != 0); end
      n_cmp++; if (y1_valid !== (q1.size() != 0)) begin n_err++; $display("FAIL stream_y1_valid got %b exp %b", y1_valid, q1.size() != 0); end
      n_cmp++; if (y0_count !== 2'(q0.size())) begin n_err++; $display("FAIL stream_y0_count got %0d exp %0d", y0_count, q0.size()); end
      n_cmp++; if (y1_count !== 2'(q1.size())) begin n_err++; $display("FAIL stream_y1_count got %0d exp %0d", y1_count, q1.size()); end
      if (q0.size() != 0) begin
        n_cmp++; if (y0 !== q0[0]) begin n_err++; $display("FAIL stream_y0 got %h exp %h", y0, q0[0]); end
      end
      if (q1.size() != 0) begin
        n_cmp++; if (y1 !== q1[0]) begin n_err++; $display("FAIL stream_y1 got %h exp %h", y1, q1[0]); end
      end
      y0_ready = 1'($urandom_range(0, 1));
      y1_ready = 1'($urandom_range(0, 1));
      in_valid = (next < 16);
      in_data  = 4'(next);
      adr      = 1'(next % 2);
      exp_rdy  = adr ? (q1.size() != 2) : (q0.size() != 2);
      #1;
      n_cmp++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL stream_in_ready got %b exp %b", in_ready, exp_rdy); end
      if (y0_ready && q0.size() != 0) begin void'(q0.pop_front()); got++; end
      if (y1_ready && q1.size() != 0) begin void'(q1.pop_front()); got++; end
      if (in_valid && exp_rdy) begin
        if (adr) q1.push_back(in_data); else q0.push_back(in_data);
        next++;
      end
    end
    @(negedge clk); idle();
    n_cmp++; if (got != 16) begin n_err++; $display("FAIL stream_total got %0d exp 16 (cycles %0d)", got, cyc); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); in_valid = 1; adr = 0; in_data = 4'h1;
    @(negedge clk); adr = 1; in_data = 4'h2;
    @(negedge clk); in_valid = 0;
    n_cmp++; if ({y0_count, y1_count} !== 4'b0101) begin n_err++; $display("FAIL ar_pre_counts got %b exp 0101", {y0_count, y1_count}); end
    #2 rst = 1;
    #1;
    n_cmp++; if ({y0_valid, y1_valid} !== 2'b00) begin n_err++; $display("FAIL ar_valids got %b exp 00", {y0_valid, y1_valid}); end
    n_cmp++; if ({y0_count, y1_count} !== 4'b0000) begin n_err++; $display("FAIL ar_counts got %b exp 0000", {y0_count, y1_count}); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ar_in_ready got %b exp 1", in_ready); end
    // a push offered across an edge while reset is held must be ignored
    in_valid = 1; adr = 0; in_data = 4'h6;
    @(negedge clk);
    n_cmp++; if (y0_count !== 2'd0) begin n_err++; $display("FAIL ar_held_push got %0d exp 0", y0_count); end
    in_valid = 0; rst = 0;
    @(negedge clk);
    n_cmp++; if ({y0_valid, y1_valid} !== 2'b00) begin n_err++; $display("FAIL ar_after got %b exp 00", {y0_valid, y1_valid}); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_full_and_pop();
    test_push_pop();
    test_empty_pop();
    test_stream();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/demux2_buf.md
DEMUX2_BUF -- requirements
Module: demux2_buf

Interface
REQ-001 SHALL have parameter W, default 4, giving the data width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, giving entries per output queue; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the upstream word this cycle.
REQ-007 SHALL have port in_data, input, W bits: the upstream word.
REQ-008 SHALL have port adr, input, 1 bit: destination select, 0 routes to y0 and 1 routes to y1.
REQ-009 SHALL have ports y0_valid/y1_valid, output, 1 bit each: the queue head is valid.
REQ-010 SHALL have ports y0_ready/y1_ready, input, 1 bit each: the downstream side takes the head.
REQ-011 SHALL have ports y0/y1, output, W bits each: the queue head data.
REQ-012 SHALL have ports y0_count/y1_count, output, $clog2(DEPTH)+1 bits each: current occupancy of each queue.

Function
REQ-013 SHALL contain two independent FIFO queues, Q0 and Q1, each DEPTH x W, each with a read pointer, a write pointer and an occupancy counter.
REQ-014 SHALL drive in_ready = (adr==0) ? (count0 != DEPTH) : (count1 != DEPTH) combinationally, with no dependence on y*_ready.
REQ-015 SHALL push in_data into the queue selected by adr on a clk edge when in_valid & in_ready, and SHALL write no queue otherwise.
REQ-016 SHALL drive yN_valid = (countN != 0) and yN = the head entry of QN, both taken straight from registers (no combinational path from inputs).
REQ-017 SHALL pop QN on a clk edge when yN_valid & yN_ready.
REQ-018 SHALL give a latency of exactly 1 cycle: a word accepted at edge k appears on yN with yN_valid=1 after edge k, provided QN was empty.
REQ-019 SHALL preserve per-queue order; there is no ordering between Q0 and Q1.
REQ-020 SHALL, on a same-cycle push and pop on one queue, perform both and leave the count unchanged; this is legal only when the count is at least 1.
REQ-021 SHALL hold in_ready=0 for a queue that is full, even when the same cycle pops that queue; no bypass on full.
REQ-022 SHALL let a pop on one queue and a push on the other in the same cycle proceed independently.
REQ-023 SHALL wrap the read and write pointers modulo DEPTH, with no lost or duplicated entries across the wrap.
REQ-024 SHALL ignore yN_ready while QN is empty: no count underflow, no pointer motion.
REQ-025 SHALL leave in_data and adr as don't-care while in_valid=0, with no state change.
REQ-026 SHALL keep y0_count/y1_count in the range 0..DEPTH at all times.

Reset
REQ-027 SHALL, while rst=1 (asynchronous, active-high), force all pointers and counts to 0, so y0_valid=y1_valid=0 and y0_count=y1_count=0.
REQ-028 SHALL treat y0/y1 as don't-care after reset; entry contents are not cleared.
REQ-029 SHALL drive in_ready=1 during and after reset, since both queues are empty.
REQ-030 SHALL, on rst asserted mid-operation, discard all queued words immediately with no partial pop or push, and SHALL accept no transfers until rst=0.

Verification
REQ-031 SHALL be verified by this scenario: reset, then one cycle with in_valid=1, adr=0, in_data=4'hA, y0_ready=0 -> next cycle y0_valid=1, y0=4'hA, y0_count=1, y1_valid=0.
REQ-032 SHALL be verified by this scenario: with DEPTH=2 and y1_ready=0, push 4'h3 then 4'h5 to adr=1 -> y1_count=2, and in_ready=0 for adr=1 while in_ready=1 for adr=0; a 3rd push with in_valid held is not accepted.
REQ-033 SHALL be verified by this scenario: Q1 full and y1_ready=1 with in_valid=1, adr=1 in the same cycle -> pop of 4'h3 only, y1_count=1, and the word is accepted the next cycle.
REQ-034 SHALL be verified by this scenario: Q0 holds 1 word, push adr=0 4'h7 with y0_ready=1 -> y0_count stays 1 and y0 becomes 4'h7 next cycle.
REQ-035 SHALL be verified by this scenario: stream 4'h0..4'hF alternating adr with random y*_ready -> y0 sees evens and y1 sees odds, in order, none lost, across several pointer wraps.
REQ-036 SHALL be verified by this scenario: both queues non-empty, rst pulsed asynchronously between edges -> y0_valid=y1_valid=0 and both counts 0 before the next edge.
